fibonacci_datapath: RTL and testbench
=====================================

Name: fibonacci_datapath

Overview:
- Datapath stage driven by the Fibonacci control FSM. It consumes En_reg1, En_reg2, En_Count, En_N and Select, and produces Stop back to the controller.
- Holds the target index N, two sequence registers, an adder, an iteration counter and a termination comparator.
- Result is F(N), presented on fib_out once Stop is high.

Parameters:
- WIDTH, 16, width of the sequence registers, adder and fib_out.
- NW, 8, width of N_in, the N register and the iteration counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- En_reg1  in  1  enables reg1 update.
- En_reg2  in  1  enables reg2 update.
- En_Count  in  1  enables the counter increment.
- En_N  in  1  loads N_in into the N register.
- Select  in  1  1 = initialise registers; 0 = iterate.
- N_in  in  NW  requested Fibonacci index.
- Stop  out  1  1 when count >= n_reg.
- fib_out  out  WIDTH  current reg1, equal to F(count).
- count  out  NW  completed iterations.
- ovf  out  1  fib_out is saturated (feature only).

Behaviour:
- Reset (reset=0, async): reg1=0, reg2=1, count=0, n_reg=0, ovf=0, sat2=0. Consequently Stop=1 and fib_out=0 during reset.
- Stop: combinational compare of registers only, count >= n_reg. No combinational path from any input.
- En_N=1: n_reg <= N_in at the edge. This is independent of Select.
- Select=1 (highest priority, enables ignored):
  - reg1 <= 0, reg2 <= 1, count <= 0, ovf <= 0, sat2 <= 0.
- Select=0 and Stop=0:
  - En_reg1: reg1 <= reg2.
  - En_reg2: reg2 <= reg1 + reg2, computed in WIDTH+1 bits. The carry is handled per the optional feature.
  - En_Count: count <= count + 1.
  - Each of the three updates uses pre-edge values.
- Select=0 and Stop=1: reg1, reg2, count and ovf hold even if enables are high, so the result is frozen.
- Invariant after k iterations with all three enables high: reg1=F(k), reg2=F(k+1), count=k.
- Latency: N rising edges with enables high after the init edge. Stop rises combinationally after the Nth edge.
- Boundary conditions:
  - N_in=0: Stop=1 right after the init edge; fib_out=0.
  - N_in=2^NW-1: the counter reaches max and never wraps, because the freeze stops it.
  - n_reg reloaded mid-run to a value below count: Stop=1 immediately via >=, and registers freeze.
  - Partial enables (e.g. only En_Count): only that register changes. No cross-check is performed.
  - reset asserted mid-operation: all state returns to reset values asynchronously. Iteration resumes only after the next Select=1 cycle.
  - Select and En_N high together: both take effect at the same edge. Stop then reflects the new n_reg against count=0.

Optional Feature:
- Macro: FIB_SAT_EN.
- Defined:
  - Adder carry-out forces reg2 <= {WIDTH{1'b1}} and sets sat2=1.
  - Any later sum involving a saturated operand stays saturated.
  - When reg1 loads from reg2, ovf <= sat2. ovf therefore flags exactly when fib_out is saturated; look-ahead overflow in reg2 alone does not set it.
- Undefined:
  - Adder wraps modulo 2^WIDTH.
  - sat2 is not implemented; ovf is tied to 0.
  - Port list is identical in both builds.

Test Plan:
- N_in=10, one cycle of Select=1/En_N=1, then all enables=1 with Select=0 -> Stop=0 for 9 edges, Stop=1 after the 10th edge; fib_out=55, count=10.
- Continue holding enables=1 for 3 more edges after Stop -> fib_out stays 55, count stays 10, reg2 stays 89.
- N_in=0 with init cycle -> Stop=1 after the init edge; fib_out=0, count=0.
- N_in=24 -> fib_out=46368, ovf=0 in both builds. N_in=25 with FIB_SAT_EN -> fib_out=65535, ovf=1. N_in=25 without the macro -> fib_out=9489, ovf=0.
- Drive reset=0 asynchronously (mid-clock) at count=5 of an N=10 run -> reg1=0, count=0, Stop=1 immediately, without waiting for a clock edge. Re-init with N=10 -> 55.
- Select=1 with En_reg1=En_reg2=En_Count=1 at count=4 -> next edge gives reg1=0, reg2=1, count=0; enables are ignored.

Source files
------------

// File: rtl/fibonacci_datapath.sv
// Fibonacci datapath: N register, two sequence registers, adder, iteration counter and Stop compare.
// Optional saturating adder with an overflow flag when FIB_SAT_EN is defined.
module fibonacci_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned NW    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             En_reg1,
  input  logic             En_reg2,
  input  logic             En_Count,
  input  logic             En_N,
  input  logic             Select,
  input  logic [NW-1:0]    N_in,
  output logic             Stop,
  output logic [WIDTH-1:0] fib_out,
  output logic [NW-1:0]    count,
  output logic             ovf
);

  logic [WIDTH-1:0] reg1_q, reg1_d;
  logic [WIDTH-1:0] reg2_q, reg2_d;
  logic [NW-1:0]    count_q, count_d;
  logic [NW-1:0]    n_q, n_d;
  logic [WIDTH-1:0] next_sum;
  logic             iterate;

  // Registers only, so the controller sees no combinational loop back through Stop.
  assign Stop    = (count_q >= n_q);
  assign fib_out = reg1_q;
  assign count   = count_q;
  assign iterate = !Select && !Stop;

`ifdef FIB_SAT_EN
  logic [WIDTH:0] sum;
  logic           sum_sat;
  logic           sat2_q, sat2_d;
  logic           ovf_q, ovf_d;

  // A saturated operand (reg2 via sat2, reg1 via ovf) keeps every later sum saturated.
  assign sum      = {1'b0, reg1_q} + {1'b0, reg2_q};
  assign sum_sat  = sum[WIDTH] | sat2_q | ovf_q;
  assign next_sum = sum_sat ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
  assign ovf      = ovf_q;

  always_comb begin
    sat2_d = sat2_q;
    ovf_d  = ovf_q;
    if (Select) begin
      sat2_d = 1'b0;
      ovf_d  = 1'b0;
    end else if (!Stop) begin
      if (En_reg1) ovf_d  = sat2_q;
      if (En_reg2) sat2_d = sum_sat;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sat2_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      sat2_q <= sat2_d;
      ovf_q  <= ovf_d;
    end
  end
`else
  assign next_sum = reg1_q + reg2_q;
  assign ovf      = 1'b0;
`endif

  always_comb begin
    reg1_d  = reg1_q;
    reg2_d  = reg2_q;
    count_d = count_q;
    n_d     = En_N ? N_in : n_q;
    if (Select) begin
      reg1_d  = '0;
      reg2_d  = WIDTH'(1);
      count_d = '0;
    end else if (iterate) begin
      if (En_reg1)  reg1_d  = reg2_q;
      if (En_reg2)  reg2_d  = next_sum;
      if (En_Count) count_d = count_q + NW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      reg1_q  <= '0;
      reg2_q  <= WIDTH'(1);
      count_q <= '0;
      n_q     <= '0;
    end else begin
      reg1_q  <= reg1_d;
      reg2_q  <= reg2_d;
      count_q <= count_d;
      n_q     <= n_d;
    end
  end

endmodule

// File: tb/tb_fibonacci_datapath.sv
// Self-checking bench for fibonacci_datapath; expected results come from a scoreboard queue
// fed by a behavioural Fibonacci model that follows the FIB_SAT_EN build choice.
module tb_fibonacci_datapath;

  localparam int unsigned W  = 16;
  localparam int unsigned NW = 8;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          En_reg1 = 1'b0, En_reg2 = 1'b0, En_Count = 1'b0, En_N = 1'b0, Select = 1'b0;
  logic [NW-1:0] N_in = '0;
  logic          Stop;
  logic [W-1:0]  fib_out;
  logic [NW-1:0] count;
  logic          ovf;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string         tag;
    logic [W-1:0]  fib;
    logic [NW-1:0] cnt;
    logic          ov;
  } exp_t;

  exp_t sb_q[$];

  fibonacci_datapath #(.WIDTH(W), .NW(NW)) dut (
    .clock    (clock),
    .reset    (reset),
    .En_reg1  (En_reg1),
    .En_reg2  (En_reg2),
    .En_Count (En_Count),
    .En_N     (En_N),
    .Select   (Select),
    .N_in     (N_in),
    .Stop     (Stop),
    .fib_out  (fib_out),
    .count    (count),
    .ovf      (ovf)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the active edge; outputs are sampled at the same point.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_en(input logic r1, input logic r2, input logic c);
    En_reg1  = r1;
    En_reg2  = r2;
    En_Count = c;
  endtask

  function automatic exp_t model(input string tag, input int n);
    exp_t          e;
    logic [W-1:0]  a, b, nb;
    logic [W:0]    s;
    logic          s2, ov, ns2;
    a  = '0;
    b  = 1;
    s2 = 1'b0;
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      s = {1'b0, a} + {1'b0, b};
`ifdef FIB_SAT_EN
      if (s[W] || s2 || ov) begin
        nb  = '1;
        ns2 = 1'b1;
      end else begin
        nb  = s[W-1:0];
        ns2 = 1'b0;
      end
`else
      nb  = s[W-1:0];
      ns2 = 1'b0;
`endif
      ov = s2;
      a  = b;
      b  = nb;
      s2 = ns2;
    end
    e.tag = tag;
    e.fib = a;
    e.cnt = NW'(n);
    e.ov  = ov;
    return e;
  endfunction

  task automatic init(input int n);
    Select = 1'b1;
    En_N   = 1'b1;
    N_in   = NW'(n);
    tick();
    Select = 1'b0;
    En_N   = 1'b0;
  endtask

  task automatic sb_pop_check();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({e.tag, "_fib"}, 32'(fib_out), 32'(e.fib));
      check_eq({e.tag, "_cnt"}, 32'(count), 32'(e.cnt));
      check_eq({e.tag, "_ovf"}, 32'(ovf), 32'(e.ov));
    end
  endtask

  // Full run: init, all enables high until Stop, then compare against the scoreboard.
  task automatic run_fib(input string tag, input int n);
    int edges;
    sb_q.push_back(model(tag, n));
    set_en(1'b0, 1'b0, 1'b0);
    init(n);
    set_en(1'b1, 1'b1, 1'b1);
    edges = 0;
    while (!Stop && edges < 600) begin
      tick();
      edges++;
    end
    check_eq({tag, "_edges"}, 32'(edges), 32'(n));
    check_eq({tag, "_stop"}, 32'(Stop), 32'd1);
    sb_pop_check();
  endtask

  initial begin
    #12;
    check_eq("rst_fib", 32'(fib_out), 32'd0);
    check_eq("rst_cnt", 32'(count), 32'd0);
    check_eq("rst_stop", 32'(Stop), 32'd1);
    check_eq("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // N=10 plus immediate Stop=0 check after init.
    set_en(1'b0, 1'b0, 1'b0);
    init(10);
    check_eq("n10_stop_after_init", 32'(Stop), 32'd0);
    run_fib("n10", 10);
    check_eq("n10_const", 32'(fib_out), 32'd55);

    // Frozen after Stop; reg2 should still hold 89, seen by extending N to 11.
    repeat (3) tick();
    check_eq("hold_fib", 32'(fib_out), 32'd55);
    check_eq("hold_cnt", 32'(count), 32'd10);
    En_N = 1'b1;
    N_in = 8'd11;
    tick();
    En_N = 1'b0;
    check_eq("hold_fib_after_reload", 32'(fib_out), 32'd55);
    check_eq("ext_stop_low", 32'(Stop), 32'd0);
    tick();
    check_eq("ext_reg2", 32'(fib_out), 32'd89);
    check_eq("ext_stop", 32'(Stop), 32'd1);

    run_fib("n0", 0);
    run_fib("n24", 24);
    check_eq("n24_const", 32'(fib_out), 32'd46368);
    run_fib("n25", 25);
`ifdef FIB_SAT_EN
    check_eq("n25_const", 32'(fib_out), 32'd65535);
    check_eq("n25_ovf_const", 32'(ovf), 32'd1);
`else
    check_eq("n25_const", 32'(fib_out), 32'd9489);
    check_eq("n25_ovf_const", 32'(ovf), 32'd0);
`endif
    run_fib("n255", 255);
    repeat (2) tick();
    check_eq("n255_nowrap", 32'(count), 32'd255);

    // Async reset mid-clock at count=5.
    set_en(1'b0, 1'b0, 1'b0);
    init(10);
    set_en(1'b1, 1'b1, 1'b1);
    repeat (5) tick();
    check_eq("pre_rst_cnt", 32'(count), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_fib", 32'(fib_out), 32'd0);
    check_eq("async_cnt", 32'(count), 32'd0);
    check_eq("async_stop", 32'(Stop), 32'd1);
    tick();
    reset = 1'b1;
    tick();
    check_eq("post_rst_frozen", 32'(count), 32'd0);
    run_fib("rerun10", 10);

    // Select overrides enables at count=4.
    set_en(1'b0, 1'b0, 1'b0);
    init(10);
    set_en(1'b1, 1'b1, 1'b1);
    repeat (4) tick();
    check_eq("sel_pre_cnt", 32'(count), 32'd4);
    Select = 1'b1;
    tick();
    Select = 1'b0;
    check_eq("sel_fib", 32'(fib_out), 32'd0);
    check_eq("sel_cnt", 32'(count), 32'd0);
    tick();
    check_eq("sel_reg2", 32'(fib_out), 32'd1);

    // Partial enables.
    set_en(1'b0, 1'b0, 1'b0);
    init(10);
    set_en(1'b0, 1'b0, 1'b1);
    repeat (3) tick();
    check_eq("part_cnt", 32'(count), 32'd3);
    check_eq("part_fib0", 32'(fib_out), 32'd0);
    set_en(1'b1, 1'b0, 1'b0);
    tick();
    check_eq("part_r1", 32'(fib_out), 32'd1);
    set_en(1'b0, 1'b1, 1'b0);
    tick();
    check_eq("part_r2_hidden", 32'(fib_out), 32'd1);
    set_en(1'b1, 1'b0, 1'b0);
    tick();
    check_eq("part_r2", 32'(fib_out), 32'd2);
    check_eq("part_cnt_held", 32'(count), 32'd3);

    // Reload N below count mid-run.
    set_en(1'b0, 1'b0, 1'b0);
    init(10);
    set_en(1'b1, 1'b1, 1'b1);
    repeat (6) tick();
    En_N = 1'b1;
    N_in = 8'd3;
    tick();
    En_N = 1'b0;
    check_eq("reload_stop", 32'(Stop), 32'd1);
    check_eq("reload_fib", 32'(fib_out), 32'd13);
    repeat (2) tick();
    check_eq("reload_fib_held", 32'(fib_out), 32'd13);
    check_eq("reload_cnt_held", 32'(count), 32'd7);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
